// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, request FSM, one-entry skid buffer, IF/ID register.
// Branch redirects beat jumps; a memory word landing during a stall parks in the skid.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        JumpTaken,
   input  logic [31:0] JumpTarget,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemReady,
   input  logic [31:0] IMemData,
   output logic [31:0] IFID_Instr,
   output logic [31:0] IFID_PCPlus4,
   output logic        IFID_Valid,
   output logic [5:0]  OpCode
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc4_q, ifid_pc4_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc4_q, skid_pc4_d;

   logic [31:0] pc_plus4;
   logic        xfer;
   logic        br_redir;
   logic        jmp_redir;

   assign pc_plus4  = pc_q + 32'd4;
   assign IMemReq   = (state_q == REQ);
   assign IMemAddr  = pc_q;
   assign xfer      = IMemReq && IMemReady;
   assign br_redir  = BranchTaken;
   // Jumps come from ID, which is frozen during a stall.
   assign jmp_redir = JumpTaken && !Stall;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc4_d   = skid_pc4_q;

      if (br_redir || jmp_redir) begin
         pc_d         = br_redir ? BranchTarget : JumpTarget;
         ifid_valid_d = 1'b0;
         state_d      = REQ;
      end else begin
         unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
               if (xfer) begin
                  pc_d = pc_plus4;
                  if (Stall) begin
                     skid_instr_d = IMemData;
                     skid_pc4_d   = pc_plus4;
                     state_d      = HOLD;
                  end else begin
                     ifid_instr_d = IMemData;
                     ifid_pc4_d   = pc_plus4;
                     ifid_valid_d = 1'b1;
                  end
               end else if (!Stall) begin
                  ifid_valid_d = 1'b0;
               end
            end
            HOLD: begin
               if (!Stall) begin
                  ifid_instr_d = skid_instr_q;
                  ifid_pc4_d   = skid_pc4_q;
                  ifid_valid_d = 1'b1;
                  skid_instr_d = 32'h0;
                  skid_pc4_d   = 32'h0;
                  state_d      = REQ;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         ifid_instr_q <= 32'h0;
         ifid_pc4_q   <= 32'h0;
         ifid_valid_q <= 1'b0;
         skid_instr_q <= 32'h0;
         skid_pc4_q   <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc4_q   <= skid_pc4_d;
      end
   end

   assign IFID_Instr   = ifid_instr_q;
   assign IFID_PCPlus4 = ifid_pc4_q;
   assign IFID_Valid   = ifid_valid_q;
   assign OpCode       = ifid_valid_q ? ifid_instr_q[31:26] : 6'h00;

endmodule
